chain_pulse_sched: RTL and testbench



---
 rtl/chain_pulse_sched.sv | 212 +++++++++++++++++++++
 tb/tb_chain_pulse_sched.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/chain_pulse_sched.sv
// Pulse-train stimulus scheduler and response monitor for one NOR-inverter delay chain.
// Optional macro CHAIN_DELAY_MEAS_EN compiles in the first-edge delay counter.
module chain_pulse_sched #(
  parameter int CNT_W     = 16,
  parameter int NP_W      = 8,
  parameter int DRAIN_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] pulse_width,
  input  logic [CNT_W-1:0] gap_width,
  input  logic [NP_W-1:0]  num_pulses,
  output logic             chain_in,
  input  logic             chain_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W:0]   out_edges,
  output logic [CNT_W-1:0] first_delay,
  output logic             timeout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // done is registered one cycle behind the DONE state, so the quiet-count
  // threshold sits three below DRAIN_CYC (DRAIN_CYC must be at least 3).
  localparam int QW = $clog2(DRAIN_CYC + 1);
  localparam logic [QW-1:0] QUIET_LAST = QW'(DRAIN_CYC - 3);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pw_q, pw_d, gw_q, gw_d, cnt_q, cnt_d;
  logic [NP_W-1:0]  rem_q, rem_d;
  logic             np_nz_q, np_nz_d;
  logic [QW-1:0]    quiet_q, quiet_d;
  logic [2:0]       sync_q;
  logic             chain_in_q, chain_in_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [CNT_W:0]   edges_q, edges_d;
  logic             timeout_q, timeout_d;
  logic             accept_s, edge_s;

  assign accept_s = (state_q == S_IDLE) && start;
  assign edge_s   = sync_q[1] ^ sync_q[2];

  // Sequencer: phase timing, pulse bookkeeping and drain quiet detection.
  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    gw_d    = gw_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    np_nz_d = np_nz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pw_d    = (pulse_width == '0) ? CNT_W'(1) : pulse_width;
          gw_d    = (gap_width == '0) ? CNT_W'(1) : gap_width;
          rem_d   = num_pulses;
          np_nz_d = (num_pulses != '0);
          cnt_d   = '0;
          state_d = (num_pulses != '0) ? S_HI : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HI: begin
        if (cnt_q == pw_q - CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_LO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LO: begin
        if (cnt_q == gw_q - CNT_W'(1)) begin
          cnt_d   = '0;
          rem_d   = rem_q - NP_W'(1);
          state_d = (rem_q == NP_W'(1)) ? S_DRAIN : S_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (!edge_s && (quiet_q == QUIET_LAST)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Quiet counter restarts on every edge and outside DRAIN.
  always_comb begin
    quiet_d = quiet_q;
    if ((state_q != S_DRAIN) || edge_s) begin
      quiet_d = '0;
    end else if (quiet_q != QUIET_LAST) begin
      quiet_d = quiet_q + QW'(1);
    end else begin
      quiet_d = quiet_q;
    end
  end

  // Registered outputs and result counters.
  always_comb begin
    chain_in_d = (state_d == S_HI);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_q == S_DONE);
    edges_d    = edges_q;
    timeout_d  = timeout_q;
    if (accept_s) begin
      edges_d   = '0;
      timeout_d = 1'b0;
    end else begin
      if (busy_q && edge_s && (edges_q != '1)) begin
        edges_d = edges_q + (CNT_W+1)'(1);
      end else begin
        edges_d = edges_q;
      end
      if ((state_q == S_DONE) && (edges_q == '0) && np_nz_q) begin
        timeout_d = 1'b1;
      end else begin
        timeout_d = timeout_q;
      end
    end
  end

  // State, capture, synchronizer and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pw_q       <= '0;
      gw_q       <= '0;
      cnt_q      <= '0;
      rem_q      <= '0;
      np_nz_q    <= 1'b0;
      quiet_q    <= '0;
      sync_q     <= '0;
      chain_in_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      edges_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pw_q       <= pw_d;
      gw_q       <= gw_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      np_nz_q    <= np_nz_d;
      quiet_q    <= quiet_d;
      sync_q     <= {sync_q[1:0], chain_out};
      chain_in_q <= chain_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      edges_q    <= edges_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef CHAIN_DELAY_MEAS_EN
  logic [CNT_W-1:0] delay_q, delay_d;
  logic             found_q, found_d;

  // Delay counts from the first HI cycle and freezes on the first detected edge.
  always_comb begin
    delay_d = delay_q;
    found_d = found_q;
    if (accept_s) begin
      delay_d = '0;
      found_d = 1'b0;
    end else if (busy_q && np_nz_q && !found_q) begin
      delay_d = (delay_q != '1) ? delay_q + CNT_W'(1) : delay_q;
      found_d = edge_s;
    end else begin
      delay_d = delay_q;
      found_d = found_q;
    end
  end

  // Delay measurement registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      delay_q <= '0;
      found_q <= 1'b0;
    end else begin
      delay_q <= delay_d;
      found_q <= found_d;
    end
  end

  assign first_delay = delay_q;
`else
  assign first_delay = '0;
`endif

  assign chain_in  = chain_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_edges = edges_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_chain_pulse_sched.sv
// Directed self-checking bench for chain_pulse_sched with an ideal 4-cycle chain
// and a pulse-filtering chain model.
module tb_chain_pulse_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pulse_width = 16'd0;
  logic [15:0] gap_width = 16'd0;
  logic [7:0]  num_pulses = 8'd0;
  logic        chain_in;
  logic        chain_out;
  logic        busy, done, timeout;
  logic [16:0] out_edges;
  logic [15:0] first_delay;

  int checks = 0;
  int errors = 0;

`ifdef CHAIN_DELAY_MEAS_EN
  localparam int EXP_DELAY = 7;
`else
  localparam int EXP_DELAY = 0;
`endif

  chain_pulse_sched dut (
    .clk(clk), .rst(rst), .start(start),
    .pulse_width(pulse_width), .gap_width(gap_width), .num_pulses(num_pulses),
    .chain_in(chain_in), .chain_out(chain_out),
    .busy(busy), .done(done), .out_edges(out_edges),
    .first_delay(first_delay), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Chain model: 4-cycle delay line; filter mode needs 3 consecutive highs.
  logic [3:0] dl = 4'b0000;
  logic       filt_mode = 1'b0;
  always @(posedge clk) dl <= {dl[2:0], chain_in};
  assign chain_out = filt_mode ? (dl[3] & dl[2] & dl[1]) : dl[3];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ideal chain, 5/5 widths, 3 pulses; inputs scrambled after acceptance.
  task automatic run_s1(input string p);
    pulse_width = 16'd5; gap_width = 16'd5; num_pulses = 8'd3; filt_mode = 1'b0;
    start = 1'b1;
    chk({p, "_busy_pre"}, 32'(busy), 32'd0);
    cyc(1);  // N+1
    start = 1'b0; pulse_width = 16'd0; gap_width = 16'd0; num_pulses = 8'd0;
    chk({p, "_ci_n1"}, 32'(chain_in), 32'd1);
    chk({p, "_busy_n1"}, 32'(busy), 32'd1);
    chk({p, "_edges_clr"}, 32'(out_edges), 32'd0);
    cyc(4);  // N+5
    chk({p, "_ci_n5"}, 32'(chain_in), 32'd1);
    cyc(1);  // N+6
    chk({p, "_ci_n6"}, 32'(chain_in), 32'd0);
    cyc(1);  // N+7
    chk({p, "_edges_n7"}, 32'(out_edges), 32'd0);
    cyc(1);  // N+8
    chk({p, "_edges_n8"}, 32'(out_edges), 32'd1);
    cyc(3);  // N+11
    chk({p, "_ci_n11"}, 32'(chain_in), 32'd1);
    cyc(84); // N+95
    chk({p, "_done_n95"}, 32'(done), 32'd0);
    chk({p, "_busy_n95"}, 32'(busy), 32'd1);
    cyc(1);  // N+96
    chk({p, "_done_n96"}, 32'(done), 32'd1);
    chk({p, "_busy_n96"}, 32'(busy), 32'd0);
    chk({p, "_edges"}, 32'(out_edges), 32'd6);
    chk({p, "_delay"}, 32'(first_delay), 32'(EXP_DELAY));
    chk({p, "_timeout"}, 32'(timeout), 32'd0);
    cyc(1);  // N+97
    chk({p, "_done_n97"}, 32'(done), 32'd0);
    chk({p, "_edges_hold"}, 32'(out_edges), 32'd6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    cyc(3);
    chk("rst_ci", 32'(chain_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_edges", 32'(out_edges), 32'd0);
    chk("rst_delay", 32'(first_delay), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    cyc(2);

    run_s1("s1");
    cyc(3);

    // Filtering chain drops 2-cycle pulses
    pulse_width = 16'd2; gap_width = 16'd2; num_pulses = 8'd4; filt_mode = 1'b1;
    start = 1'b1;
    cyc(1);  // N+1
    start = 1'b0;
    chk("s2_ci_n1", 32'(chain_in), 32'd1);
    cyc(2);  // N+3
    chk("s2_ci_n3", 32'(chain_in), 32'd0);
    cyc(76); // N+79
    chk("s2_done_n79", 32'(done), 32'd0);
    cyc(1);  // N+80
    chk("s2_done_n80", 32'(done), 32'd1);
    chk("s2_edges", 32'(out_edges), 32'd0);
    chk("s2_timeout", 32'(timeout), 32'd1);
    cyc(3);
    filt_mode = 1'b0;

    // Zero pulses
    pulse_width = 16'd5; gap_width = 16'd5; num_pulses = 8'd0;
    start = 1'b1;
    cyc(1);  // N+1
    start = 1'b0;
    chk("s3_busy_n1", 32'(busy), 32'd1);
    chk("s3_done_n1", 32'(done), 32'd0);
    chk("s3_ci_n1", 32'(chain_in), 32'd0);
    chk("s3_timeout_clr", 32'(timeout), 32'd0);
    cyc(1);  // N+2
    chk("s3_done_n2", 32'(done), 32'd1);
    chk("s3_busy_n2", 32'(busy), 32'd0);
    chk("s3_ci_n2", 32'(chain_in), 32'd0);
    chk("s3_edges", 32'(out_edges), 32'd0);
    chk("s3_delay", 32'(first_delay), 32'd0);
    chk("s3_timeout", 32'(timeout), 32'd0);
    cyc(1);  // N+3
    chk("s3_done_n3", 32'(done), 32'd0);
    cyc(2);

    // Zero widths clamp to one cycle
    pulse_width = 16'd0; gap_width = 16'd0; num_pulses = 8'd2;
    start = 1'b1;
    cyc(1);  // N+1
    start = 1'b0;
    chk("s4_ci_n1", 32'(chain_in), 32'd1);
    cyc(1);
    chk("s4_ci_n2", 32'(chain_in), 32'd0);
    cyc(1);
    chk("s4_ci_n3", 32'(chain_in), 32'd1);
    cyc(1);
    chk("s4_ci_n4", 32'(chain_in), 32'd0);
    cyc(1);
    chk("s4_ci_n5", 32'(chain_in), 32'd0);
    cyc(68); // N+73
    chk("s4_done_n73", 32'(done), 32'd0);
    cyc(1);  // N+74
    chk("s4_done_n74", 32'(done), 32'd1);
    chk("s4_edges", 32'(out_edges), 32'd4);
    chk("s4_delay", 32'(first_delay), 32'(EXP_DELAY));
    cyc(3);

    // Start while busy is ignored, then reset mid-HI
    pulse_width = 16'd10; gap_width = 16'd3; num_pulses = 8'd2;
    start = 1'b1;
    cyc(1);  // N+1
    start = 1'b0;
    cyc(1);  // N+2
    start = 1'b1; pulse_width = 16'd1; num_pulses = 8'd0;
    cyc(1);  // N+3
    start = 1'b0;
    chk("s5_busy_n3", 32'(busy), 32'd1);
    chk("s5_ci_n3", 32'(chain_in), 32'd1);
    cyc(1);  // N+4
    chk("s5_ci_n4", 32'(chain_in), 32'd1);
    chk("s5_done_n4", 32'(done), 32'd0);
    cyc(1);  // N+5
    rst = 1'b1;
    cyc(1);  // N+6
    rst = 1'b0;
    chk("s5_rst_ci", 32'(chain_in), 32'd0);
    chk("s5_rst_busy", 32'(busy), 32'd0);
    chk("s5_rst_done", 32'(done), 32'd0);
    chk("s5_rst_edges", 32'(out_edges), 32'd0);
    chk("s5_rst_delay", 32'(first_delay), 32'd0);
    chk("s5_rst_timeout", 32'(timeout), 32'd0);
    cyc(6);  // N+12, residual chain activity has passed
    chk("s5_resid_edges", 32'(out_edges), 32'd0);
    chk("s5_resid_busy", 32'(busy), 32'd0);
    chk("s5_resid_delay", 32'(first_delay), 32'd0);
    cyc(6);

    run_s1("s5_fresh");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
